instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage that sits directly upstream of the control unit and datapath.
//  - Holds the PC and issues in-order requests to instruction memory.
//  - Buffers returned words in a small FIFO.
//  - Presents {instr, instr_pc} to decode over a valid/ready handshake.
//  - Branch/jump redirect flushes the buffer and discards in-flight responses.
//  Decode takes op=instr[6:0], funct3=instr[14:12], funct7=instr[31:25].
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset; must be word-aligned
//  FIFO_DEPTH  2              instruction buffer entries; power of 2, >=2
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst             in   1   reset; asynchronous, active-high
//  imem_req        out  1   fetch request valid
//  imem_addr       out  32  fetch address (= pc_q)
//  imem_gnt        in   1   request accepted this cycle
//  imem_rvalid     in   1   response valid; responses return in request order
//  imem_rdata      in   32  response instruction word
//  redirect        in   1   branch/jump taken; restart fetch at redirect_pc
//  redirect_pc     in   32  redirect target
//  instr_valid     out  1   head-of-buffer instruction valid to decode
//  instr_ready     in   1   decode accepts head instruction
//  instr           out  32  instruction word
//  instr_pc        out  32  PC of instr
//  fetch_misalign  out  1   only with IF_ALIGN_CHK_EN; otherwise tied 0
// BEHAVIOUR
//  Reset values:
//  - pc_q=RESET_PC, rsp_pc_q=RESET_PC; outstanding=0; discard=0; FIFO empty.
//  - state=FETCH; imem_req=0 during reset; instr_valid=0; fetch_misalign=0.
//  Credits: imem_req=1 in FETCH iff outstanding+fifo_count < FIFO_DEPTH and
//  redirect=0, so every response is guaranteed a FIFO slot.
//  Request accept (req&gnt): pc_q<=pc_q+4 (mod 2^32, 0xFFFF_FFFC wraps to 0);
//  outstanding+1.
//  Response (rvalid):
//  - discard>0: word dropped; discard-1; outstanding-1.
//  - else push {rdata, rsp_pc_q}; rsp_pc_q+=4; outstanding-1.
//  - A response may arrive the cycle after grant at the earliest.
//  Output: instr_valid = FIFO non-empty; pop on instr_valid&instr_ready.
//  Latency: grant at cycle N with rvalid at N+1 gives instr_valid at N+2.
//  Redirect (takes effect at the next edge):
//  - FIFO flushed; pc_q<=redirect_pc; rsp_pc_q<=redirect_pc.
//  - discard<=outstanding, net of any response discarded that cycle.
//  - No request is issued in the redirect cycle.
//  - Redirect beats same-cycle pop (pop ignored) and same-cycle rvalid
//    (word discarded).
//  FSM (2 states):
//  - FETCH: issue requests per credit rule.
//  - DRAIN: no requests; wait for discard==0.
//  - FETCH->DRAIN on redirect with nonzero discard count; otherwise stays FETCH.
//  - DRAIN->FETCH when discard reaches 0.
//  - Redirect in DRAIN: updates pc_q/rsp_pc_q, keeps counting discards.
//  Reset mid-operation: all state clears immediately; imem must also be reset,
//  and no response may arrive for a pre-reset request.
// CONFIGURATION
//  IF_ALIGN_CHK_EN defined:
//  - Redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1.
//  - Flushes as normal, issues no further requests, and holds instr_valid=0.
//  - The next aligned redirect clears fetch_misalign and restarts fetch.
//  IF_ALIGN_CHK_EN undefined: redirect_pc[1:0] ignored (forced to 0);
//  fetch_misalign tied 0.
// STRUCTURE
//  Package if_pkg:
//  - INSTR_W=32, XLEN=32, RV_NOP=32'h0000_0013.
//  - Enum if_state_t {FETCH, DRAIN}.
//  Sub-module fetch_fifo:
//  - Synchronous FIFO of {instr, pc}, depth FIFO_DEPTH.
//  - push/pop/flush; flush has priority over push and pop; exposes count.
// TESTING
//  1 Reset release, gnt=1, rvalid one cycle after gnt, ready=1
//    -> instr_pc sequence 0,4,8,... with instr matching rdata in order.
//  2 instr_ready=0 with FIFO_DEPTH=2 -> exactly 2 grants, then imem_req=0;
//    ready=1 resumes fetch with no word lost or duplicated.
//  3 Redirect to 0x100 with 2 outstanding -> both responses dropped;
//    first instr_pc=0x100.
//  4 Redirect, same-cycle rvalid and pop -> instr_valid=0 next cycle;
//    that word is never delivered.
//  5 PC at 0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
//  6 (IF_ALIGN_CHK_EN) redirect_pc=0x102 -> fetch_misalign=1, no req;
//    redirect 0x200 -> flag clears, fetch restarts at 0x200.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

  localparam int INSTR_W = 32;
  localparam int XLEN    = 32;
  localparam logic [INSTR_W-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} if_state_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous {instr, pc} buffer between imem responses and decode.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [INSTR_W-1:0]            wr_instr,
  input  logic [XLEN-1:0]               wr_pc,
  output logic [INSTR_W-1:0]            rd_instr,
  output logic [XLEN-1:0]               rd_pc,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int AW = $clog2(DEPTH);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0]    pc_mem    [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        cnt;

  // Pointer and occupancy tracking; flush wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty so it carries no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem[wr_ptr] <= wr_instr;
      pc_mem[wr_ptr]    <= wr_pc;
    end
  end

  assign rd_instr = instr_mem[rd_ptr];
  assign rd_pc    = pc_mem[rd_ptr];
  assign empty    = (cnt == '0);
  assign count    = cnt;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, response buffering, redirect.
// Optional misaligned-redirect trap enabled by defining IF_ALIGN_CHK_EN.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_misalign
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  if_state_t          state;
  if_state_t          state_next;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    rsp_pc_q;
  logic [XLEN-1:0]    target;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      outstanding_next;
  logic [CW-1:0]      discard;
  logic [CW-1:0]      discard_next;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        credit_used;
  logic               fifo_empty;
  logic               accept;
  logic               push;
  logic               pop;
  logic               misalign_q;
  logic [INSTR_W-1:0] head_instr;
  logic [XLEN-1:0]    head_pc;

  assign target = align_pc(redirect_pc);

`ifdef IF_ALIGN_CHK_EN
  // A misaligned target parks fetch until the next aligned redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect) begin
      misalign_q <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign misalign_q = 1'b0;
`endif

  // Request credits, response routing and next-state decode.
  always_comb begin
    credit_used      = {1'b0, outstanding} + {1'b0, fifo_count};
    imem_req         = 1'b0;
    accept           = 1'b0;
    push             = 1'b0;
    pop              = 1'b0;
    outstanding_next = outstanding;
    discard_next     = discard;
    state_next       = state;

    if (!rst && state == FETCH && !redirect && !misalign_q && credit_used < DEPTH_C) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
    accept = imem_req & imem_gnt;
    push   = imem_rvalid & (discard == '0) & ~redirect;
    pop    = instr_valid & instr_ready & ~redirect;

    case ({accept, imem_rvalid})
      2'b10:   outstanding_next = outstanding + 1'b1;
      2'b01:   outstanding_next = outstanding - 1'b1;
      default: outstanding_next = outstanding;
    endcase

    // Every request still in flight at a redirect belongs to the old stream.
    if (redirect) begin
      discard_next = outstanding - {{(CW-1){1'b0}}, imem_rvalid};
    end else if (imem_rvalid && discard != '0) begin
      discard_next = discard - 1'b1;
    end else begin
      discard_next = discard;
    end

    case (state)
      FETCH: begin
        if (redirect && discard_next != '0) state_next = DRAIN;
        else                                state_next = FETCH;
      end
      DRAIN: begin
        if (discard_next == '0) state_next = FETCH;
        else                    state_next = DRAIN;
      end
      default: state_next = FETCH;
    endcase
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (redirect) begin
        pc_q     <= target;
        rsp_pc_q <= target;
      end else begin
        if (accept) pc_q     <= pc_next(pc_q);
        if (push)   rsp_pc_q <= pc_next(rsp_pc_q);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .wr_instr (imem_rdata),
    .wr_pc    (rsp_pc_q),
    .rd_instr (head_instr),
    .rd_pc    (head_pc),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign imem_addr      = pc_q;
  assign instr_valid    = ~fifo_empty & ~misalign_q;
  assign instr          = instr_valid ? head_instr : RV_NOP;
  assign instr_pc       = head_pc;
  assign fetch_misalign = misalign_q;

endmodule
